lsu_mem_stage: RTL and testbench

- Parametrised memory-stage load/store unit between the ALU stage and write-back.
- Drives a request/grant/rvalid data-memory interface.
- Supports byte, half and word loads and stores, with sign or zero extension on loads.
- Stalls the pipeline while a transaction is outstanding, passes non-memory results through in one cycle, and flags response timeouts.

---
 rtl/lsu_mem_stage.sv | 193 +++++++++++++++++++
 tb/tb_lsu_mem_stage.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_stage.sv
// Memory-stage load/store unit: req/gnt/rvalid data port, sized loads/stores, ALU pass-through, timeout.
// Optional LSU_MISALIGN_TRAP_EN: misaligned half/word accesses raise an error instead of being force-aligned.
module lsu_mem_stage #(
  parameter int ADDR_W         = 32,
  parameter int RVALID_TIMEOUT = 16,
  parameter int REG_ADDR_W     = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  ex_valid_i,
  input  logic                  lsu_en_i,
  input  logic                  lsu_we_i,
  input  logic [1:0]            lsu_size_i,
  input  logic                  lsu_unsigned_i,
  input  logic [ADDR_W-1:0]     mem_addr_i,
  input  logic [31:0]           store_data_i,
  input  logic [31:0]           alu_result_i,
  input  logic [REG_ADDR_W-1:0] rd_addr_i,
  input  logic                  rd_we_i,
  output logic                  stall_o,
  output logic                  data_req_o,
  input  logic                  data_gnt_i,
  output logic [ADDR_W-1:0]     data_addr_o,
  output logic                  data_we_o,
  output logic [3:0]            data_be_o,
  output logic [31:0]           data_wdata_o,
  input  logic                  data_rvalid_i,
  input  logic [31:0]           data_rdata_i,
  output logic                  wb_valid_o,
  output logic [31:0]           wb_data_o,
  output logic [REG_ADDR_W-1:0] wb_rd_addr_o,
  output logic                  wb_rd_we_o,
  output logic                  err_o
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_e;

  localparam int CNT_W = (RVALID_TIMEOUT > 1) ? $clog2(RVALID_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((RVALID_TIMEOUT > 0) ? RVALID_TIMEOUT - 1 : 0);

  state_e                  state_q, state_d;
  logic [ADDR_W-1:0]       addr_q;
  logic [1:0]              size_q;
  logic                    uns_q, we_q, rd_we_q;
  logic [31:0]             wdata_q;
  logic [REG_ADDR_W-1:0]   rd_addr_q;
  logic [CNT_W-1:0]        cnt_q;

  logic       accept, alu_pass, misalign, bad_acc, go_req, timeout;
  logic [1:0] addr_lo;
  logic [31:0] shifted, load_val;

  assign accept   = (state_q == S_IDLE) && ex_valid_i && lsu_en_i;
  assign alu_pass = (state_q == S_IDLE) && ex_valid_i && !lsu_en_i;

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign = ((lsu_size_i == 2'b01) && mem_addr_i[0]) ||
                    ((lsu_size_i == 2'b10) && (mem_addr_i[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign bad_acc = accept && ((lsu_size_i == 2'b11) || misalign);
  assign go_req  = accept && !bad_acc;
  assign timeout = (RVALID_TIMEOUT > 0) && (state_q == S_WAIT) && !data_rvalid_i && (cnt_q == TO_LAST);

  // Low address bits forced to the access alignment (no-op when trapping rejects them first)
  always_comb begin
    addr_lo = mem_addr_i[1:0];
    case (lsu_size_i)
      2'b01:   addr_lo[0] = 1'b0;
      2'b10:   addr_lo    = 2'b00;
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (go_req) state_d = S_REQ;
      S_REQ:   if (data_gnt_i) state_d = S_WAIT;
      S_WAIT:  if (data_rvalid_i || timeout) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    stall_o      = (state_q != S_IDLE);
    data_req_o   = 1'b0;
    data_addr_o  = '0;
    data_we_o    = 1'b0;
    data_be_o    = 4'b0000;
    data_wdata_o = 32'h0;
    if (state_q == S_REQ) begin
      data_req_o  = 1'b1;
      data_addr_o = {addr_q[ADDR_W-1:2], 2'b00};
      data_we_o   = we_q;
      case (size_q)
        2'b00: begin
          data_be_o    = 4'b0001 << addr_q[1:0];
          data_wdata_o = {4{wdata_q[7:0]}};
        end
        2'b01: begin
          data_be_o    = 4'b0011 << {addr_q[1], 1'b0};
          data_wdata_o = {2{wdata_q[15:0]}};
        end
        default: begin
          data_be_o    = 4'b1111;
          data_wdata_o = wdata_q;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      addr_q    <= '0;
      size_q    <= 2'b00;
      uns_q     <= 1'b0;
      we_q      <= 1'b0;
      wdata_q   <= 32'h0;
      rd_addr_q <= '0;
      rd_we_q   <= 1'b0;
    end else if (accept) begin
      addr_q    <= {mem_addr_i[ADDR_W-1:2], addr_lo};
      size_q    <= lsu_size_i;
      uns_q     <= lsu_unsigned_i;
      we_q      <= lsu_we_i;
      wdata_q   <= store_data_i;
      rd_addr_q <= rd_addr_i;
      rd_we_q   <= rd_we_i;
    end
  end

  // Counter sits at zero outside WAIT, so it is clear on every WAIT entry
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                   cnt_q <= '0;
    else if (state_q != S_WAIT)   cnt_q <= '0;
    else if (!data_rvalid_i)      cnt_q <= cnt_q + 1'b1;
  end

  assign shifted = data_rdata_i >> {addr_q[1:0], 3'b000};

  always_comb begin
    case (size_q)
      2'b00:   load_val = {{24{~uns_q & shifted[7]}},  shifted[7:0]};
      2'b01:   load_val = {{16{~uns_q & shifted[15]}}, shifted[15:0]};
      default: load_val = shifted;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wb_valid_o   <= 1'b0;
      wb_data_o    <= 32'h0;
      wb_rd_addr_o <= '0;
      wb_rd_we_o   <= 1'b0;
      err_o        <= 1'b0;
    end else begin
      wb_valid_o <= 1'b0;
      err_o      <= 1'b0;
      if (alu_pass) begin
        wb_valid_o   <= 1'b1;
        wb_data_o    <= alu_result_i;
        wb_rd_addr_o <= rd_addr_i;
        wb_rd_we_o   <= rd_we_i;
      end else if (bad_acc) begin
        wb_valid_o   <= 1'b1;
        err_o        <= 1'b1;
        wb_data_o    <= 32'h0;
        wb_rd_addr_o <= rd_addr_i;
        wb_rd_we_o   <= 1'b0;
      end else if (state_q == S_WAIT && data_rvalid_i) begin
        wb_valid_o   <= 1'b1;
        wb_data_o    <= we_q ? 32'h0 : load_val;
        wb_rd_addr_o <= rd_addr_q;
        wb_rd_we_o   <= rd_we_q && !we_q;
      end else if (timeout) begin
        wb_valid_o   <= 1'b1;
        err_o        <= 1'b1;
        wb_data_o    <= 32'h0;
        wb_rd_addr_o <= rd_addr_q;
        wb_rd_we_o   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed bench for lsu_mem_stage: stores, sized loads, ALU pass-through, errors, timeout, reset abort.
module tb_lsu_mem_stage;

  logic        clock, reset;
  logic        ex_valid_i, lsu_en_i, lsu_we_i, lsu_unsigned_i, rd_we_i;
  logic [1:0]  lsu_size_i;
  logic [31:0] mem_addr_i, store_data_i, alu_result_i;
  logic [4:0]  rd_addr_i;
  logic        stall_o, data_req_o, data_gnt_i, data_we_o, data_rvalid_i;
  logic [31:0] data_addr_o, data_wdata_o, data_rdata_i, wb_data_o;
  logic [3:0]  data_be_o;
  logic        wb_valid_o, wb_rd_we_o, err_o;
  logic [4:0]  wb_rd_addr_o;

  int checks = 0;
  int errors = 0;

  lsu_mem_stage #(.ADDR_W(32), .RVALID_TIMEOUT(16), .REG_ADDR_W(5)) dut (
    .clock(clock), .reset(reset),
    .ex_valid_i(ex_valid_i), .lsu_en_i(lsu_en_i), .lsu_we_i(lsu_we_i),
    .lsu_size_i(lsu_size_i), .lsu_unsigned_i(lsu_unsigned_i),
    .mem_addr_i(mem_addr_i), .store_data_i(store_data_i), .alu_result_i(alu_result_i),
    .rd_addr_i(rd_addr_i), .rd_we_i(rd_we_i), .stall_o(stall_o),
    .data_req_o(data_req_o), .data_gnt_i(data_gnt_i), .data_addr_o(data_addr_o),
    .data_we_o(data_we_o), .data_be_o(data_be_o), .data_wdata_o(data_wdata_o),
    .data_rvalid_i(data_rvalid_i), .data_rdata_i(data_rdata_i),
    .wb_valid_o(wb_valid_o), .wb_data_o(wb_data_o), .wb_rd_addr_o(wb_rd_addr_o),
    .wb_rd_we_o(wb_rd_we_o), .err_o(err_o)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock); #1;
  endtask

  // Drive one instruction for a single cycle, then drop ex_valid
  task automatic issue(input logic en, input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] alu,
                       input logic [4:0] rd, input logic rdwe);
    ex_valid_i = 1'b1; lsu_en_i = en; lsu_we_i = we; lsu_size_i = size; lsu_unsigned_i = uns;
    mem_addr_i = addr; store_data_i = wd; alu_result_i = alu; rd_addr_i = rd; rd_we_i = rdwe;
    check("stall_at_issue", 32'(stall_o), 32'h0);
    step();
    ex_valid_i = 1'b0; lsu_en_i = 1'b0;
  endtask

  // Memory side: grant after gnt_dly REQ cycles, rvalid rv_dly cycles after grant
  task automatic serve(input int gnt_dly, input int rv_dly, input logic [31:0] rdata,
                       input logic [31:0] eaddr, input logic [3:0] ebe, input logic [31:0] ewd,
                       input logic ewe, input int estall);
    int st;
    st = 0;
    for (int i = 0; i <= gnt_dly; i++) begin
      check("req", 32'(data_req_o), 32'h1);
      check("addr", data_addr_o, eaddr);
      check("be", 32'(data_be_o), 32'(ebe));
      check("wdata", data_wdata_o, ewd);
      check("we", 32'(data_we_o), 32'(ewe));
      st += int'(stall_o);
      if (i == gnt_dly) data_gnt_i = 1'b1;
      step();
    end
    data_gnt_i = 1'b0;
    for (int i = 0; i < rv_dly; i++) begin
      check("req_low_wait", 32'(data_req_o), 32'h0);
      st += int'(stall_o);
      if (i == rv_dly - 1) begin data_rvalid_i = 1'b1; data_rdata_i = rdata; end
      step();
    end
    data_rvalid_i = 1'b0;
    check("stall_cycles", 32'(st), 32'(estall));
  endtask

  task automatic expect_wb(input string tag, input logic [31:0] data, input logic [4:0] rd,
                           input logic rdwe, input logic err);
    check({tag, "_valid"}, 32'(wb_valid_o), 32'h1);
    check({tag, "_data"},  wb_data_o, data);
    check({tag, "_rd"},    32'(wb_rd_addr_o), 32'(rd));
    check({tag, "_rdwe"},  32'(wb_rd_we_o), 32'(rdwe));
    check({tag, "_err"},   32'(err_o), 32'(err));
    check({tag, "_stall"}, 32'(stall_o), 32'h0);
    step();
    check({tag, "_pulse"}, 32'({wb_valid_o, err_o}), 32'h0);
  endtask

  initial begin
    int n;
    reset = 1'b0;
    ex_valid_i = 0; lsu_en_i = 0; lsu_we_i = 0; lsu_size_i = 0; lsu_unsigned_i = 0;
    mem_addr_i = 0; store_data_i = 0; alu_result_i = 0; rd_addr_i = 0; rd_we_i = 0;
    data_gnt_i = 0; data_rvalid_i = 0; data_rdata_i = 0;
    step(); step();
    check("rst_state", 32'({stall_o, data_req_o, wb_valid_o, err_o, wb_rd_we_o}), 32'h0);
    check("rst_wbdata", wb_data_o, 32'h0);
    check("rst_addr", data_addr_o, 32'h0);
    #2 reset = 1'b1;
    step();

    // SW 0x100
    issue(1, 1, 2'b10, 0, 32'h100, 32'hDEADBEEF, 0, 5'd4, 1);
    serve(0, 1, 32'h0, 32'h100, 4'b1111, 32'hDEADBEEF, 1, 2);
    expect_wb("sw", 32'h0, 5'd4, 0, 0);

    // LB / LBU 0x103
    issue(1, 0, 2'b00, 0, 32'h103, 0, 0, 5'd5, 1);
    serve(0, 1, 32'h80FFFF7F, 32'h100, 4'b1000, 32'h0, 0, 2);
    expect_wb("lb", 32'hFFFFFF80, 5'd5, 1, 0);
    issue(1, 0, 2'b00, 1, 32'h103, 0, 0, 5'd6, 1);
    serve(0, 1, 32'h80FFFF7F, 32'h100, 4'b1000, 32'h0, 0, 2);
    expect_wb("lbu", 32'h00000080, 5'd6, 1, 0);

    // LH 0x102 with grant delayed 3 cycles
    issue(1, 0, 2'b01, 0, 32'h102, 0, 0, 5'd7, 1);
    serve(3, 1, 32'h80011234, 32'h100, 4'b1100, 32'h0, 0, 5);
    expect_wb("lh", 32'hFFFF8001, 5'd7, 1, 0);

    // SB / SH replication, slower response
    issue(1, 1, 2'b00, 0, 32'h201, 32'h12345678, 0, 5'd0, 0);
    serve(1, 2, 32'h0, 32'h200, 4'b0010, 32'h78787878, 1, 4);
    expect_wb("sb", 32'h0, 5'd0, 0, 0);
    issue(1, 1, 2'b01, 0, 32'h202, 32'h0000ABCD, 0, 5'd0, 0);
    serve(0, 1, 32'h0, 32'h200, 4'b1100, 32'hABCDABCD, 1, 2);
    expect_wb("sh", 32'h0, 5'd0, 0, 0);

    // LHU low half
    issue(1, 0, 2'b01, 1, 32'h300, 0, 0, 5'd9, 1);
    serve(0, 1, 32'h1234F00D, 32'h300, 4'b0011, 32'h0, 0, 2);
    expect_wb("lhu", 32'h0000F00D, 5'd9, 1, 0);

    // ALU pass-through
    issue(0, 0, 2'b00, 0, 32'h0, 0, 32'h55, 5'd3, 1);
    expect_wb("alu", 32'h55, 5'd3, 1, 0);

    // Illegal size
    issue(1, 0, 2'b11, 0, 32'h400, 0, 0, 5'd8, 1);
    check("ill_req", 32'(data_req_o), 32'h0);
    expect_wb("ill", 32'h0, 5'd8, 0, 1);

    // Timeout: 16 WAIT cycles without rvalid
    issue(1, 0, 2'b10, 0, 32'h500, 0, 0, 5'd10, 1);
    data_gnt_i = 1'b1;
    step();
    data_gnt_i = 1'b0;
    n = 0;
    while (stall_o && n < 40) begin n++; step(); end
    check("to_wait_cycles", 32'(n), 32'd16);
    expect_wb("to", 32'h0, 5'd10, 0, 1);
    data_rvalid_i = 1'b1; data_rdata_i = 32'hFFFFFFFF;
    step();
    data_rvalid_i = 1'b0;
    check("stray_rvalid", 32'({wb_valid_o, err_o, stall_o, data_req_o}), 32'h0);

    // Misaligned LW 0x101
    issue(1, 0, 2'b10, 0, 32'h101, 0, 0, 5'd11, 1);
`ifdef LSU_MISALIGN_TRAP_EN
    check("mis_req", 32'(data_req_o), 32'h0);
    expect_wb("mis", 32'h0, 5'd11, 0, 1);
`else
    serve(0, 1, 32'hCAFEF00D, 32'h100, 4'b1111, 32'h0, 0, 2);
    expect_wb("mis", 32'hCAFEF00D, 5'd11, 1, 0);
`endif

    // Reset mid-transaction abandons the access; late rvalid is ignored
    issue(1, 0, 2'b10, 0, 32'h600, 0, 0, 5'd12, 1);
    check("abort_req", 32'(data_req_o), 32'h1);
    #2 reset = 1'b0;
    #1 check("abort_idle", 32'({stall_o, data_req_o}), 32'h0);
    #2 reset = 1'b1;
    step();
    data_rvalid_i = 1'b1; data_rdata_i = 32'h12345678;
    step();
    data_rvalid_i = 1'b0;
    check("abort_late_rv", 32'({wb_valid_o, err_o, stall_o}), 32'h0);
    issue(0, 0, 2'b00, 0, 32'h0, 0, 32'hA5A5A5A5, 5'd1, 1);
    expect_wb("post_rst", 32'hA5A5A5A5, 5'd1, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
